// File: rtl/adder_bcd_fnd.sv
`default_nettype none
// ============================================================================
//  Module   : adder_bcd_fnd
//  Purpose  : Adds two unsigned operands, converts the sum to four BCD digits
//             and drives one digit of a multiplexed 4-digit common-anode
//             7-segment display (active-low anodes and segments).
//  Revision : 1.0  initial release
// ============================================================================
module adder_bcd_fnd #(
  parameter int WIDTH = 4   // operand width, 1..12 so the sum fits 4 decimal digits
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_A,
  input  logic [WIDTH-1:0] i_B,
  input  logic [1:0]       i_digitSelect,
  input  logic             i_en,
  output logic [3:0]       o_digit,
  output logic [7:0]       o_font
);

  localparam int SUM_W = WIDTH + 1;       // sum width with carry kept
  localparam int DD_W  = 16 + SUM_W;      // double-dabble scratch: 4 BCD digits + binary

  localparam logic [3:0] BLANK_DIGIT = 4'b1111;
  localparam logic [7:0] BLANK_FONT  = 8'hFF;

  logic [SUM_W-1:0] sum;
  logic [15:0]      bcd;
  logic [3:0]       sel_bcd;
  logic [3:0]       digit_d, digit_q;
  logic [7:0]       font_d,  font_q;
  logic [DD_W-1:0]  dd;

  // Full-width sum so the carry out of the operands is never lost
  always_comb begin
    sum = {1'b0, i_A} + {1'b0, i_B};
  end

  // Double-dabble: shift the sum left through the BCD field, adding 3 to any
  // digit that is 5 or more before each shift so it carries correctly.
  always_comb begin
    dd = '0;
    dd[SUM_W-1:0] = sum;
    for (int i = 0; i < SUM_W; i++) begin
      for (int d = 0; d < 4; d++) begin
        if (dd[SUM_W + 4*d +: 4] >= 4'd5) begin
          dd[SUM_W + 4*d +: 4] = dd[SUM_W + 4*d +: 4] + 4'd3;
        end
      end
      dd = dd << 1;
    end
    bcd = dd[SUM_W +: 16];
  end

  // Pick the BCD digit for the scanned position
  always_comb begin
    sel_bcd = bcd[3:0];
    case (i_digitSelect)
      2'd0: sel_bcd = bcd[3:0];
      2'd1: sel_bcd = bcd[7:4];
      2'd2: sel_bcd = bcd[11:8];
      2'd3: sel_bcd = bcd[15:12];
      default: sel_bcd = bcd[3:0];
    endcase
  end

  // Anode select and active-low segment font; disabled display is blank
  always_comb begin
    digit_d = BLANK_DIGIT;
    font_d  = BLANK_FONT;
    if (i_en) begin
      case (i_digitSelect)
        2'd0: digit_d = 4'b1110;
        2'd1: digit_d = 4'b1101;
        2'd2: digit_d = 4'b1011;
        2'd3: digit_d = 4'b0111;
        default: digit_d = BLANK_DIGIT;
      endcase
      case (sel_bcd)
        4'd0: font_d = 8'hC0;
        4'd1: font_d = 8'hF9;
        4'd2: font_d = 8'hA4;
        4'd3: font_d = 8'hB0;
        4'd4: font_d = 8'h99;
        4'd5: font_d = 8'h92;
        4'd6: font_d = 8'h82;
        4'd7: font_d = 8'hF8;
        4'd8: font_d = 8'h80;
        4'd9: font_d = 8'h90;
        default: font_d = BLANK_FONT;  // non-decimal code cannot occur
      endcase
    end
  end

  // Output register; reset blanks the display and overrides everything
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      digit_q <= BLANK_DIGIT;
      font_q  <= BLANK_FONT;
    end else begin
      digit_q <= digit_d;
      font_q  <= font_d;
    end
  end

  assign o_digit = digit_q;
  assign o_font  = font_q;

endmodule
`default_nettype wire

// File: tb/tb_adder_bcd_fnd.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adder_bcd_fnd
//  Purpose  : Directed self-checking bench for adder_bcd_fnd (WIDTH=4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_adder_bcd_fnd;

  localparam int WIDTH = 4;

  logic             i_clk;
  logic             i_reset;
  logic [WIDTH-1:0] i_A;
  logic [WIDTH-1:0] i_B;
  logic [1:0]       i_digitSelect;
  logic             i_en;
  logic [3:0]       o_digit;
  logic [7:0]       o_font;

  int n_checks;
  int n_errors;

  adder_bcd_fnd #(.WIDTH(WIDTH)) u_dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_A           (i_A),
    .i_B           (i_B),
    .i_digitSelect (i_digitSelect),
    .i_en          (i_en),
    .o_digit       (o_digit),
    .o_font        (o_font)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Single comparison point: counts and reports mismatches
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply inputs, wait one rising edge, then settle 1 time unit before sampling
  task automatic apply(input int a, input int b, input int sel, input logic en);
    i_A           = 4'(a);
    i_B           = 4'(b);
    i_digitSelect = 2'(sel);
    i_en          = en;
    @(posedge i_clk);
    #1;
  endtask

  // Reference font for a decimal digit (active-low, dp off)
  function automatic logic [7:0] ref_font(input int d);
    case (d)
      0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
      4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
      8: return 8'h80;  9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [3:0] ref_anode(input int sel);
    case (sel)
      0: return 4'b1110;  1: return 4'b1101;
      2: return 4'b1011;  default: return 4'b0111;
    endcase
  endfunction

  initial begin
    int s;
    int dig;
    n_checks = 0;
    n_errors = 0;

    // Reset for two cycles with display enabled
    i_reset = 1'b1;
    apply(9, 9, 0, 1'b1);
    check("rst1_digit", 16'(o_digit), 16'h000F);
    check("rst1_font",  16'(o_font),  16'h00FF);
    apply(5, 3, 1, 1'b1);
    check("rst2_digit", 16'(o_digit), 16'h000F);
    check("rst2_font",  16'(o_font),  16'h00FF);

    // First edge after release shows current inputs: 1+1=2
    i_reset = 1'b0;
    apply(1, 1, 0, 1'b1);
    check("rel_digit", 16'(o_digit), 16'h000E);
    check("rel_font",  16'(o_font),  16'h00A4);

    // Enable gating
    apply(1, 1, 0, 1'b0);
    check("en0_digit", 16'(o_digit), 16'h000F);
    check("en0_font",  16'(o_font),  16'h00FF);
    for (int k = 2; k <= 4; k++) begin
      apply(k, k, 0, 1'b0);
      check("en0_sweep_digit", 16'(o_digit), 16'h000F);
      check("en0_sweep_font",  16'(o_font),  16'h00FF);
    end
    apply(4, 4, 0, 1'b1);
    check("en1_4p4_digit", 16'(o_digit), 16'h000E);
    check("en1_4p4_font",  16'(o_font),  16'h0080);

    // 9+9=18
    apply(9, 9, 0, 1'b1);
    check("18_s0_font",  16'(o_font),  16'h0080);
    check("18_s0_digit", 16'(o_digit), 16'h000E);
    apply(9, 9, 1, 1'b1);
    check("18_s1_font",  16'(o_font),  16'h00F9);
    check("18_s1_digit", 16'(o_digit), 16'h000D);
    apply(9, 9, 2, 1'b1);
    check("18_s2_font",  16'(o_font),  16'h00C0);
    check("18_s2_digit", 16'(o_digit), 16'h000B);

    // Maximum sum 15+15=30
    apply(15, 15, 1, 1'b1);
    check("30_s1_font",  16'(o_font),  16'h00B0);
    apply(15, 15, 0, 1'b1);
    check("30_s0_font",  16'(o_font),  16'h00C0);
    apply(15, 15, 3, 1'b1);
    check("30_s3_font",  16'(o_font),  16'h00C0);
    check("30_s3_digit", 16'(o_digit), 16'h0007);

    // 0+0 all digits show "0"
    apply(0, 0, 2, 1'b1);
    check("0_s2_font", 16'(o_font), 16'h00C0);

    // Latency: input change is invisible until the next rising edge
    apply(2, 0, 0, 1'b1);
    check("lat_before", 16'(o_font), 16'h00A4);
    i_A = 4'd7;
    #2;
    check("lat_hold", 16'(o_font), 16'h00A4);
    @(posedge i_clk);
    #1;
    check("lat_after", 16'(o_font), 16'h00F8);

    // Reset mid-operation blanks at the next edge, then recovers
    i_reset = 1'b1;
    apply(7, 8, 1, 1'b1);
    check("midrst_digit", 16'(o_digit), 16'h000F);
    check("midrst_font",  16'(o_font),  16'h00FF);
    i_reset = 1'b0;
    apply(7, 8, 1, 1'b1);
    check("postrst_font",  16'(o_font),  16'h00F9);
    check("postrst_digit", 16'(o_digit), 16'h000D);

    // Exhaustive operand pairs and selects
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int sel = 0; sel < 4; sel++) begin
          apply(a, b, sel, 1'b1);
          s = a + b;
          case (sel)
            0: dig = s % 10;
            1: dig = (s / 10) % 10;
            2: dig = (s / 100) % 10;
            default: dig = (s / 1000) % 10;
          endcase
          check("exh_font",  16'(o_font),  16'(ref_font(dig)));
          check("exh_digit", 16'(o_digit), 16'(ref_anode(sel)));
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
